// File: rtl/fifo_pkg.sv
// Shared helpers for the multi-lane FIFO: lane counting, mask shape and modulo pointer add.
package fifo_pkg;
    localparam int MAXW = 32;

    function automatic int unsigned popcount(input logic [MAXW-1:0] v);
        int unsigned n = 0;
        for (int i = 0; i < MAXW; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

    // A thermometer mask has no set bit above a clear bit, so v & (v+1) is zero.
    function automatic logic is_thermo(input logic [MAXW-1:0] v);
        return (v & (v + MAXW'(1))) == '0;
    endfunction

    // Inputs are bounded (ptr < depth, inc <= depth) so one conditional subtract wraps.
    function automatic int unsigned wrap_add(input int unsigned ptr, input int unsigned inc,
                                             input int unsigned depth);
        int unsigned s = ptr + inc;
        if (s >= depth) begin
            s -= depth;
        end
        return s;
    endfunction
endpackage

// File: rtl/fifo_multi_if.sv
// Push/pop/status bundle between a multi-lane FIFO and the pipeline stages around it.
interface fifo_multi_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int PUSHES     = 2,
    parameter int POPS       = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                                 flush;
    logic [PUSHES-1:0][DATA_WIDTH-1:0]    push_data;
    logic [PUSHES-1:0]                    push_valid;
    logic                                 push_accept;
    logic [POPS-1:0][DATA_WIDTH-1:0]      pop_data;
    logic [POPS-1:0]                      pop_valid;
    logic [POPS-1:0]                      pop;
    logic [CNT_W-1:0]                     items;
    logic [CNT_W-1:0]                     free;
    logic                                 empty;
    logic                                 full;
    logic                                 almost_full;

    modport master (
        output flush, push_data, push_valid, pop,
        input  push_accept, pop_data, pop_valid, items, free, empty, full, almost_full
    );

    modport slave (
        input  flush, push_data, push_valid, pop,
        output push_accept, pop_data, pop_valid, items, free, empty, full, almost_full
    );
endinterface

// File: rtl/fifo_ptr.sv
// Circular-buffer pointer: advances by a variable increment modulo DEPTH, cleared by flush.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int INC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [INC_W-1:0] inc,
    output logic [IDX_W-1:0] ptr
);
    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] ptr_next;

    always_comb begin
        ptr_next = IDX_W'(wrap_add(32'(ptr_reg), 32'(inc), 32'(DEPTH)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (flush) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;
endmodule

// File: rtl/fifo_multi.sv
// Multi-push/multi-pop circular FIFO with first-word fall-through outputs and synchronous flush.
module fifo_multi
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int PUSHES     = 2,
    parameter int POPS       = 2,
    parameter int AF_MARGIN  = 2
) (
    input logic           clk,
    input logic           reset,
    fifo_multi_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]      head;
    logic [IDX_W-1:0]      tail;
    logic [CNT_W-1:0]      items_reg;
    logic [CNT_W-1:0]      items_next;
    logic [CNT_W-1:0]      free_cnt;
    logic [CNT_W-1:0]      np;
    logic [CNT_W-1:0]      nq;
    logic [CNT_W-1:0]      tail_inc;
    logic                  accept;
    logic [POPS-1:0]       pop_valid;
    logic [POPS-1:0]       pop_eff;

    // Only the registered free count is used, so slots popped this cycle are not reused yet.
    always_comb begin
        free_cnt   = CNT_W'(DEPTH) - items_reg;
        np         = CNT_W'(popcount(MAXW'(bus.push_valid)));
        accept     = (np != '0) && (np <= free_cnt);
        pop_eff    = bus.pop & pop_valid;
        nq         = CNT_W'(popcount(MAXW'(pop_eff)));
        tail_inc   = accept ? np : '0;
        items_next = items_reg + tail_inc - nq;
    end

    fifo_ptr #(.DEPTH(DEPTH), .IDX_W(IDX_W), .INC_W(CNT_W)) u_tail (
        .clk(clk), .reset(reset), .flush(bus.flush), .inc(tail_inc), .ptr(tail)
    );

    fifo_ptr #(.DEPTH(DEPTH), .IDX_W(IDX_W), .INC_W(CNT_W)) u_head (
        .clk(clk), .reset(reset), .flush(bus.flush), .inc(nq), .ptr(head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            items_reg <= '0;
        end else if (bus.flush) begin
            items_reg <= '0;
        end else begin
            items_reg <= items_next;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !bus.flush) begin
            for (int i = 0; i < PUSHES; i++) begin
                if (bus.push_valid[i]) begin
                    mem[IDX_W'(wrap_add(32'(tail), 32'(i), 32'(DEPTH)))] <= bus.push_data[i];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < POPS; gi++) begin : g_pop_lane
            assign pop_valid[gi]    = int'(items_reg) > gi;
            assign bus.pop_data[gi] = pop_valid[gi]
                ? mem[IDX_W'(wrap_add(32'(head), 32'(gi), 32'(DEPTH)))] : '0;
        end
    endgenerate

    assign bus.pop_valid   = pop_valid;
    assign bus.push_accept = accept;
    assign bus.items       = items_reg;
    assign bus.free        = free_cnt;
    assign bus.empty       = (items_reg == '0);
    assign bus.full        = (items_reg == CNT_W'(DEPTH));
    assign bus.almost_full = int'(items_reg) >= (DEPTH - AF_MARGIN);

    a_params: assert property (@(posedge clk)
        DEPTH >= 2 && PUSHES >= 1 && PUSHES <= DEPTH && POPS >= 1 && POPS <= DEPTH &&
        AF_MARGIN >= 0 && AF_MARGIN <= DEPTH - 1 && DATA_WIDTH >= 1 &&
        PUSHES <= MAXW && POPS <= MAXW);
    a_push_thermo: assert property (@(posedge clk) disable iff (reset)
        is_thermo(MAXW'(bus.push_valid)));
    a_pop_thermo: assert property (@(posedge clk) disable iff (reset)
        is_thermo(MAXW'(bus.pop)));
    a_pop_subset: assert property (@(posedge clk) disable iff (reset)
        (bus.pop & ~pop_valid) == '0);
    a_items_range: assert property (@(posedge clk) disable iff (reset)
        items_reg <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_fifo_multi.sv
// Directed bench for fifo_multi at DEPTH=6, two push and two pop lanes, 8-bit data.
module tb_fifo_multi;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fifo_multi_if #(.DATA_WIDTH(8), .DEPTH(6), .PUSHES(2), .POPS(2)) bus ();

    fifo_multi #(.DATA_WIDTH(8), .DEPTH(6), .PUSHES(2), .POPS(2), .AF_MARGIN(1)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.push_valid = 2'b00;
        bus.pop        = 2'b00;
        bus.flush      = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bus.items !== 3'd0) begin failures++; $display("FAIL reset_items got=%0d exp=0", bus.items); end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
        checks++; if (bus.free !== 3'd6) begin failures++; $display("FAIL reset_free got=%0d exp=6", bus.free); end
        checks++; if (bus.almost_full !== 1'b0) begin failures++; $display("FAIL reset_af got=%b exp=0", bus.almost_full); end
        checks++; if (bus.pop_valid !== 2'b00) begin failures++; $display("FAIL reset_pop_valid got=%b exp=00", bus.pop_valid); end
        checks++; if (bus.pop_data !== 16'h0000) begin failures++; $display("FAIL reset_pop_data got=%h exp=0000", bus.pop_data); end
        checks++; if (bus.push_accept !== 1'b0) begin failures++; $display("FAIL reset_accept got=%b exp=0", bus.push_accept); end
        $display("test_reset done items=%0d", bus.items);
        #1 reset = 1'b0;
    endtask

    task automatic test_push_pair();
        bus.push_data[0] = 8'hA1; bus.push_data[1] = 8'hA2; bus.push_valid = 2'b11;
        #1;
        checks++; if (bus.push_accept !== 1'b1) begin failures++; $display("FAIL pair_accept got=%b exp=1", bus.push_accept); end
        step();
        idle();
        #1;
        checks++; if (bus.items !== 3'd2) begin failures++; $display("FAIL pair_items got=%0d exp=2", bus.items); end
        checks++; if (bus.pop_valid !== 2'b11) begin failures++; $display("FAIL pair_pop_valid got=%b exp=11", bus.pop_valid); end
        checks++; if (bus.pop_data !== 16'hA2A1) begin failures++; $display("FAIL pair_pop_data got=%h exp=a2a1", bus.pop_data); end
        checks++; if (bus.empty !== 1'b0) begin failures++; $display("FAIL pair_empty got=%b exp=0", bus.empty); end
        checks++; if (bus.free !== 3'd4) begin failures++; $display("FAIL pair_free got=%0d exp=4", bus.free); end
        $display("test_push_pair pushed a1,a2 items=%0d", bus.items);
    endtask

    task automatic test_full();
        bus.push_data[0] = 8'hB1; bus.push_data[1] = 8'hB2; bus.push_valid = 2'b11;
        step();
        bus.push_data[0] = 8'hC1; bus.push_valid = 2'b01;
        step();
        bus.push_data[0] = 8'hD1; bus.push_data[1] = 8'hD2; bus.push_valid = 2'b11;
        #1;
        checks++; if (bus.items !== 3'd5) begin failures++; $display("FAIL fill_items got=%0d exp=5", bus.items); end
        checks++; if (bus.almost_full !== 1'b1) begin failures++; $display("FAIL fill_af got=%b exp=1", bus.almost_full); end
        checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL fill_full got=%b exp=0", bus.full); end
        checks++; if (bus.push_accept !== 1'b0) begin failures++; $display("FAIL over_accept got=%b exp=0", bus.push_accept); end
        step();
        checks++; if (bus.items !== 3'd5) begin failures++; $display("FAIL over_items got=%0d exp=5", bus.items); end
        bus.push_data[0] = 8'h77; bus.push_valid = 2'b01;
        #1;
        checks++; if (bus.push_accept !== 1'b1) begin failures++; $display("FAIL last_accept got=%b exp=1", bus.push_accept); end
        step();
        idle();
        #1;
        checks++; if (bus.items !== 3'd6) begin failures++; $display("FAIL full_items got=%0d exp=6", bus.items); end
        checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", bus.full); end
        checks++; if (bus.free !== 3'd0) begin failures++; $display("FAIL full_free got=%0d exp=0", bus.free); end
        $display("test_full items=%0d full=%b", bus.items, bus.full);
    endtask

    task automatic test_full_pop();
        bus.pop = 2'b11;
        bus.push_data[0] = 8'hEE; bus.push_valid = 2'b01;
        #1;
        checks++; if (bus.push_accept !== 1'b0) begin failures++; $display("FAIL fullpop_accept got=%b exp=0", bus.push_accept); end
        step();
        idle();
        #1;
        checks++; if (bus.items !== 3'd4) begin failures++; $display("FAIL fullpop_items got=%0d exp=4", bus.items); end
        checks++; if (bus.pop_data !== 16'hB2B1) begin failures++; $display("FAIL fullpop_head got=%h exp=b2b1", bus.pop_data); end
        $display("test_full_pop items=%0d head=%h", bus.items, bus.pop_data[0]);
    endtask

    task automatic test_wrap();
        logic [7:0] exp_q [$];
        logic [7:0] d;
        exp_q = '{8'hB1, 8'hB2, 8'hC1, 8'h77};
        d = 8'h10;
        for (int c = 0; c < 10; c++) begin
            bus.push_data[0] = d; bus.push_data[1] = d + 8'd1;
            bus.push_valid = 2'b11; bus.pop = 2'b11;
            #1;
            checks++; if (bus.pop_data[0] !== exp_q[0]) begin failures++; $display("FAIL wrap_lane0 cyc=%0d got=%h exp=%h", c, bus.pop_data[0], exp_q[0]); end
            checks++; if (bus.pop_data[1] !== exp_q[1]) begin failures++; $display("FAIL wrap_lane1 cyc=%0d got=%h exp=%h", c, bus.pop_data[1], exp_q[1]); end
            checks++; if (bus.items !== 3'd4) begin failures++; $display("FAIL wrap_items cyc=%0d got=%0d exp=4", c, bus.items); end
            checks++; if (bus.push_accept !== 1'b1) begin failures++; $display("FAIL wrap_accept cyc=%0d got=%b exp=1", c, bus.push_accept); end
            $display("wrap cyc=%0d popped %h,%h pushed %h,%h", c, bus.pop_data[0], bus.pop_data[1], d, d + 8'd1);
            step();
            void'(exp_q.pop_front()); void'(exp_q.pop_front());
            exp_q.push_back(d); exp_q.push_back(d + 8'd1);
            d = d + 8'd2;
        end
        idle();
        #1;
        checks++; if (bus.pop_data !== {exp_q[1], exp_q[0]}) begin failures++; $display("FAIL wrap_final got=%h exp=%h%h", bus.pop_data, exp_q[1], exp_q[0]); end
    endtask

    task automatic test_flush();
        bus.pop = 2'b01;
        step();
        idle();
        #1;
        checks++; if (bus.items !== 3'd3) begin failures++; $display("FAIL preflush_items got=%0d exp=3", bus.items); end
        bus.flush = 1'b1;
        bus.push_data[0] = 8'h55; bus.push_data[1] = 8'h66; bus.push_valid = 2'b11;
        step();
        idle();
        #1;
        checks++; if (bus.items !== 3'd0) begin failures++; $display("FAIL flush_items got=%0d exp=0", bus.items); end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL flush_empty got=%b exp=1", bus.empty); end
        checks++; if (bus.pop_valid !== 2'b00) begin failures++; $display("FAIL flush_pop_valid got=%b exp=00", bus.pop_valid); end
        bus.push_data[0] = 8'h99; bus.push_valid = 2'b01;
        step();
        idle();
        #1;
        checks++; if (bus.pop_data[0] !== 8'h99) begin failures++; $display("FAIL postflush_head got=%h exp=99", bus.pop_data[0]); end
        checks++; if (dut.mem[0] !== 8'h99) begin failures++; $display("FAIL postflush_slot0 got=%h exp=99", dut.mem[0]); end
        checks++; if (bus.items !== 3'd1) begin failures++; $display("FAIL postflush_items got=%0d exp=1", bus.items); end
        $display("test_flush items=%0d head=%h", bus.items, bus.pop_data[0]);
    endtask

    task automatic test_async_reset();
        bus.push_data[0] = 8'h9A; bus.push_data[1] = 8'h9B; bus.push_valid = 2'b11;
        step();
        bus.push_data[0] = 8'h9C; bus.push_valid = 2'b01;
        step();
        idle();
        #1;
        checks++; if (bus.items !== 3'd4) begin failures++; $display("FAIL prereset_items got=%0d exp=4", bus.items); end
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.items !== 3'd0) begin failures++; $display("FAIL areset_items got=%0d exp=0", bus.items); end
        checks++; if (bus.pop_valid !== 2'b00) begin failures++; $display("FAIL areset_pop_valid got=%b exp=00", bus.pop_valid); end
        #1 reset = 1'b0;
        bus.push_data[0] = 8'h5A; bus.push_valid = 2'b01;
        step();
        idle();
        #1;
        checks++; if (bus.pop_valid !== 2'b01) begin failures++; $display("FAIL single_pop_valid got=%b exp=01", bus.pop_valid); end
        checks++; if (bus.pop_data !== 16'h005A) begin failures++; $display("FAIL single_pop_data got=%h exp=005a", bus.pop_data); end
        bus.pop = 2'b01;
        step();
        idle();
        #1;
        checks++; if (bus.items !== 3'd0) begin failures++; $display("FAIL single_pop_items got=%0d exp=0", bus.items); end
        checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL single_pop_empty got=%b exp=1", bus.empty); end
        $display("test_async_reset items=%0d", bus.items);
    endtask

    initial begin
        idle();
        bus.push_data = '0;
        test_reset();
        test_push_pair();
        test_full();
        test_full_pop();
        test_wrap();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
